// File: rtl/alu_decoder_mc.sv
// alu_decoder_mc
//   Registered ALU control decoder for the MIPS datapath. Maps the main
//   decoder's alu_op class and the R-type funct field to a CTRL_W-bit ALU
//   control code (zero-extended 4-bit codes), flags unsupported functs, and
//   sequences fixed-latency multiply/divide operations with a stall.
//
//   Build option: define ALU_DEC_MD_EN to compile in the mult/div sequencer
//   (IDLE/RUN/DONE FSM, latency counter, md_* outputs). Without it the
//   mult/div functs decode as illegal single-cycle ops, in_ready is tied
//   high and all md_* / stall outputs are tied low.
//
// Parameters
//   CTRL_W      width of alu_control (>= 4)
//   MD_LATENCY  cycles a mult/div op occupies the unit (>= 2)
//
// Ports
//   clk, reset       clock (rising edge), async active-high reset
//   in_valid/ready   upstream handshake for funct/alu_op
//   funct, alu_op    instruction funct field, main-decoder class
//   alu_control      registered ALU op code
//   out_valid        one-cycle pulse qualifying alu_control/illegal
//   illegal          funct unsupported (qualified by out_valid)
//   md_start         one-cycle launch pulse to the mult/div unit
//   md_op            00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held while busy
//   md_busy, stall   mult/div op in flight (stall mirrors md_busy)

module alu_decoder_mc #(
  parameter int CTRL_W     = 4,
  parameter int MD_LATENCY = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        funct,
  input  logic [1:0]        alu_op,
  output logic [CTRL_W-1:0] alu_control,
  output logic              out_valid,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy,
  output logic              stall
);

  // Elaboration-time parameter sanity checks.
  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("alu_decoder_mc: CTRL_W must be at least 4");
  end
  if (MD_LATENCY < 2) begin : g_bad_latency
    $error("alu_decoder_mc: MD_LATENCY must be at least 2");
  end

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_NOR  = 4'b0101;
  localparam logic [3:0] C_SLT  = 4'b0110;
  localparam logic [3:0] C_SLTU = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_SRA  = 4'b1010;
  localparam logic [3:0] C_MD   = 4'b1111;

  typedef struct packed {
    logic [3:0] code;
    logic       ill;
    logic       md;
  } dec_t;

  dec_t dec;

  // Combinational decode of the presented request; only consumed at the
  // accepting edge, so nothing upstream is registered here.
  always_comb begin
    dec = '{code: C_ADD, ill: 1'b0, md: 1'b0};
    case (alu_op)
      2'b00: dec.code = C_ADD;
      2'b01: dec.code = C_SUB;
      2'b11: dec.code = C_SLT;
      default: begin
        case (funct)
          6'b100000, 6'b100001: dec.code = C_ADD;
          6'b100010, 6'b100011: dec.code = C_SUB;
          6'b100100:            dec.code = C_AND;
          6'b100101:            dec.code = C_OR;
          6'b100110:            dec.code = C_XOR;
          6'b100111:            dec.code = C_NOR;
          6'b101010:            dec.code = C_SLT;
          6'b101011:            dec.code = C_SLTU;
          6'b000000:            dec.code = C_SLL;
          6'b000010:            dec.code = C_SRL;
          6'b000011:            dec.code = C_SRA;
`ifdef ALU_DEC_MD_EN
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec.code = C_MD;
            dec.md   = 1'b1;
          end
`endif
          default:              dec.ill  = 1'b1;  // code stays ADD
        endcase
      end
    endcase
  end

`ifdef ALU_DEC_MD_EN

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W = $clog2(MD_LATENCY);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign in_ready = (state == IDLE);
  assign stall    = md_busy;

  // Counter is loaded only from IDLE and holds at 0 on the RUN->DONE edge,
  // so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_control <= '0;
      out_valid   <= 1'b0;
      illegal     <= 1'b0;
      md_start    <= 1'b0;
      md_op       <= 2'b00;
      md_busy     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      md_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dec.md) begin
              state    <= RUN;
              cnt      <= CNT_W'(MD_LATENCY - 1);
              md_op    <= funct[1:0];
              md_start <= 1'b1;
              md_busy  <= 1'b1;
            end else begin
              alu_control <= CTRL_W'(dec.code);
              illegal     <= dec.ill;
              out_valid   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state       <= DONE;
            md_busy     <= 1'b0;
            alu_control <= CTRL_W'(C_MD);
            illegal     <= 1'b0;
            out_valid   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign in_ready = 1'b1;
  assign md_start = 1'b0;
  assign md_op    = 2'b00;
  assign md_busy  = 1'b0;
  assign stall    = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_control <= '0;
      out_valid   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_control <= CTRL_W'(dec.code);
        illegal     <= dec.ill;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_decoder_mc.sv
module tb_alu_decoder_mc;

  localparam int CTRL_W = 4;
  localparam int MD_LAT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        funct = 6'd0;
  logic [1:0]        alu_op = 2'b00;
  logic [CTRL_W-1:0] alu_control;
  logic              out_valid;
  logic              illegal;
  logic              md_start;
  logic [1:0]        md_op;
  logic              md_busy;
  logic              stall;

  int checks   = 0;
  int failures = 0;

  alu_decoder_mc #(.CTRL_W(CTRL_W), .MD_LATENCY(MD_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .alu_op(alu_op), .alu_control(alu_control),
    .out_valid(out_valid), .illegal(illegal), .md_start(md_start),
    .md_op(md_op), .md_busy(md_busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"},  32'(alu_control), 32'd0);
    chk({tag, "_ov"},    32'(out_valid),   32'd0);
    chk({tag, "_ill"},   32'(illegal),     32'd0);
    chk({tag, "_start"}, 32'(md_start),    32'd0);
    chk({tag, "_mdop"},  32'(md_op),       32'd0);
    chk({tag, "_busy"},  32'(md_busy),     32'd0);
    chk({tag, "_stall"}, 32'(stall),       32'd0);
    chk({tag, "_rdy"},   32'(in_ready),    32'd1);
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] code, input logic ill);
    in_valid = 1'b1; alu_op = op; funct = f;
    tick();
    chk({tag, "_ov"},   32'(out_valid),   32'd1);
    chk({tag, "_ctrl"}, 32'(alu_control), 32'(code));
    chk({tag, "_ill"},  32'(illegal),     32'(ill));
  endtask

  initial begin
    logic seen;
    #2;
    chk_reset_vals("reset");
    tick(); tick();
    reset = 1'b0;

    // alu_op classes ignore funct
    single("op00", 2'b00, 6'b101010, 4'b0000, 1'b0);
    single("op01", 2'b01, 6'b000000, 4'b0001, 1'b0);
    single("op11", 2'b11, 6'b111111, 4'b0110, 1'b0);

    // back-to-back R-type, one transfer per cycle
    single("and",  2'b10, 6'b100100, 4'b0010, 1'b0);
    single("sltu", 2'b10, 6'b101011, 4'b0111, 1'b0);
    single("sra",  2'b10, 6'b000011, 4'b1010, 1'b0);
    single("subu", 2'b10, 6'b100011, 4'b0001, 1'b0);
    single("nor",  2'b10, 6'b100111, 4'b0101, 1'b0);
    single("srl",  2'b10, 6'b000010, 4'b1001, 1'b0);

    // unsupported funct
    single("bad", 2'b10, 6'b111111, 4'b0000, 1'b1);
    chk("bad_busy", 32'(md_busy), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("idle_ov", 32'(out_valid), 32'd0);

`ifdef ALU_DEC_MD_EN
    // DIV with in_valid held and an ADD queued behind it
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011010;
    tick();
    funct = 6'b100000;
    chk("md_start1", 32'(md_start), 32'd1);
    chk("md_op",     32'(md_op),    32'd2);
    chk("md_busy1",  32'(md_busy),  32'd1);
    chk("md_stall1", 32'(stall),    32'd1);
    chk("md_rdy1",   32'(in_ready), 32'd0);
    chk("md_ov1",    32'(out_valid),32'd0);
    for (int i = 2; i <= MD_LAT; i++) begin
      tick();
      chk($sformatf("md_busy%0d", i),  32'(md_busy),   32'd1);
      chk($sformatf("md_start%0d", i), 32'(md_start),  32'd0);
      chk($sformatf("md_ov%0d", i),    32'(out_valid), 32'd0);
    end
    tick();
    chk("done_busy", 32'(md_busy),     32'd0);
    chk("done_stall",32'(stall),       32'd0);
    chk("done_ov",   32'(out_valid),   32'd1);
    chk("done_ctrl", 32'(alu_control), 32'hf);
    chk("done_ill",  32'(illegal),     32'd0);
    chk("done_rdy",  32'(in_ready),    32'd0);
    tick();
    chk("back_ov",  32'(out_valid), 32'd0);
    chk("back_rdy", 32'(in_ready),  32'd1);
    tick();
    chk("add_ov",   32'(out_valid),   32'd1);
    chk("add_ctrl", 32'(alu_control), 32'd0);

    // reset in the second RUN cycle aborts the op
    funct = 6'b011011;
    tick();
    chk("ab_start", 32'(md_start), 32'd1);
    chk("ab_mdop",  32'(md_op),    32'd3);
    in_valid = 1'b0;
    tick();
    chk("ab_busy2", 32'(md_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < MD_LAT + 4; i++) begin
      tick();
      if (out_valid || md_start || md_busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
`else
    // mult/div functs are plain illegal ops in this build
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011000;
    tick();
    chk("nomd_ov",    32'(out_valid),   32'd1);
    chk("nomd_ill",   32'(illegal),     32'd1);
    chk("nomd_ctrl",  32'(alu_control), 32'd0);
    chk("nomd_stall", 32'(stall),       32'd0);
    chk("nomd_rdy",   32'(in_ready),    32'd1);
    chk("nomd_start", 32'(md_start),    32'd0);
    funct = 6'b011011;
    tick();
    chk("nomd2_ill",  32'(illegal),     32'd1);
    in_valid = 1'b0;
    tick();
    chk("nomd_ov0",   32'(out_valid),   32'd0);
    chk("nomd_stall2",32'(stall),       32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
